// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALUOp
// codes, datapath select codes, FSM state encodings and the Moore decode.
package mips_ctrl_defs;

  localparam int OPW  = 6;
  localparam int AOPW = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;

  localparam logic [AOPW-1:0] ALU_ADD   = 3'b000;
  localparam logic [AOPW-1:0] ALU_SUB   = 3'b001;
  localparam logic [AOPW-1:0] ALU_RTYPE = 3'b010;
  localparam logic [AOPW-1:0] ALU_OR    = 3'b011;
  localparam logic [AOPW-1:0] ALU_AND   = 3'b100;
  localparam logic [AOPW-1:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  // Moore-type control bundle; PCWrite and IRWrite are handled separately
  // because they depend on same-cycle inputs.
  typedef struct packed {
    logic            iord;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            regdst;
    logic            regwrite;
    logic            alusrca;
    logic [1:0]      alusrcb;
    logic [1:0]      pcsource;
    logic [AOPW-1:0] aluop;
  } ctrl_t;

  // Immediate-class ALU operation chosen by opcode
  function automatic logic [AOPW-1:0] imm_aluop(input logic [OPW-1:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Control levels held for the whole time the FSM sits in state st
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [OPW-1:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
      end
      S_DECODE:   c.alusrcb = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEM_WB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEM_WR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_R_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_RTYPE;
      end
      S_R_WB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALU_SUB;
        c.pcsource = PCSRC_ALUOUT;
      end
      S_JUMP:   c.pcsource = PCSRC_JUMP;
      S_I_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = imm_aluop(op);
      end
      S_I_WB:   c.regwrite = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Datapath-facing bundle of the control unit: decoded inputs from the
// datapath/memory and every control line going back out.
interface multi_cycle_control_unit_if;
  import mips_ctrl_defs::*;

  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            mem_ready;
  logic            PCWrite;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            MemtoReg;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSource;
  logic [AOPW-1:0] ALUOp;
  logic            illegal_op;
  logic [3:0]      state_dbg;

  modport master (
    output opcode, zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op, state_dbg
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op, state_dbg
  );

endinterface

// File: rtl/ctrl_next_state.sv
// Next-state logic of the multi-cycle control FSM, including detection of
// opcodes the decoder does not recognise.
module ctrl_next_state
  import mips_ctrl_defs::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output state_t         next_state,
  output logic           illegal
);

  // Pick the successor state; memory states hold until the access completes
  always_comb begin
    next_state = S_IDLE;
    illegal    = 1'b0;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      next_state = S_MEM_ADDR;
          OP_RTYPE:                          next_state = S_R_EXEC;
          OP_BEQ, OP_BNE:                    next_state = S_BRANCH;
          OP_J:                              next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_I_EXEC;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   next_state = S_FETCH;
      S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   next_state = S_R_WB;
      S_R_WB:     next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_I_EXEC:   next_state = S_I_WB;
      S_I_WB:     next_state = S_FETCH;
      default:    next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Main control FSM of the multi-cycle MIPS datapath. Level controls are
// registered from the state being entered so they line up with the state;
// PCWrite/IRWrite follow mem_ready and zero within the same cycle.
module multi_cycle_control_unit
  import mips_ctrl_defs::*;
(
  input  logic clk,
  input  logic rst_n,
  multi_cycle_control_unit_if.slave bus
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   illegal_next;
  logic   illegal_q;
  logic   branch_ne;

  ctrl_next_state u_next (
    .state      (state),
    .opcode     (bus.opcode),
    .mem_ready  (bus.mem_ready),
    .next_state (next_state),
    .illegal    (illegal_next)
  );

  // State register with controls, illegal pulse and branch sense captured on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      branch_ne <= 1'b0;
    end else begin
      state     <= next_state;
      ctrl_q    <= decode_ctrl(next_state, bus.opcode);
      illegal_q <= illegal_next;
      if (next_state == S_BRANCH)
        branch_ne <= (bus.opcode == OP_BNE);
    end
  end

  assign bus.IorD       = ctrl_q.iord;
  assign bus.MemRead    = ctrl_q.memread;
  assign bus.MemWrite   = ctrl_q.memwrite;
  assign bus.MemtoReg   = ctrl_q.memtoreg;
  assign bus.RegDst     = ctrl_q.regdst;
  assign bus.RegWrite   = ctrl_q.regwrite;
  assign bus.ALUSrcA    = ctrl_q.alusrca;
  assign bus.ALUSrcB    = ctrl_q.alusrcb;
  assign bus.PCSource   = ctrl_q.pcsource;
  assign bus.ALUOp      = ctrl_q.aluop;
  assign bus.illegal_op = illegal_q;
  assign bus.state_dbg  = state;

  assign bus.IRWrite = (state == S_FETCH) && bus.mem_ready;
  assign bus.PCWrite = ((state == S_FETCH) && bus.mem_ready) ||
                       (state == S_JUMP) ||
                       ((state == S_BRANCH) && (branch_ne ? !bus.zero : bus.zero));

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: per-instruction cycle
// traces built from instruction semantics, replayed with random wait states.
module tb_multi_cycle_control_unit;

  typedef struct packed {
    logic       pcw, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       z;
    logic [5:0] op;
    ctl_t       c;
  } cyc_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   pend_illegal;
  cyc_t q[$];

  multi_cycle_control_unit_if bus();

  multi_cycle_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t obs_ctl();
    ctl_t o;
    o = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
         bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
         bus.PCSource, bus.ALUOp, bus.illegal_op};
    return o;
  endfunction

  function automatic cyc_t blank(input logic [3:0] st, input logic [5:0] op);
    cyc_t r;
    r.st  = st;
    r.op  = op;
    r.rdy = 1'($urandom);
    r.z   = 1'($urandom);
    r.c   = '0;
    return r;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction
  task automatic model_instr(input logic [5:0] op, input bit z, input int wf, input int wm);
    cyc_t r;
    for (int i = 0; i <= wf; i++) begin
      r = blank(4'd1, 6'($urandom));
      r.rdy = (i == wf);
      r.c.mr = 1'b1;
      r.c.asb = 2'b01;
      r.c.irw = r.rdy;
      r.c.pcw = r.rdy;
      r.c.ill = (i == 0) && pend_illegal;
      q.push_back(r);
    end
    pend_illegal = 1'b0;
    r = blank(4'd2, op);
    r.c.asb = 2'b11;
    q.push_back(r);
    case (op)
      6'b100011, 6'b101011: begin
        r = blank(4'd3, op);
        r.c.asa = 1'b1;
        r.c.asb = 2'b10;
        q.push_back(r);
        for (int i = 0; i <= wm; i++) begin
          r = blank((op == 6'b100011) ? 4'd4 : 4'd6, op);
          r.rdy = (i == wm);
          r.c.iord = 1'b1;
          if (op == 6'b100011) r.c.mr = 1'b1;
          else                 r.c.mw = 1'b1;
          q.push_back(r);
        end
        if (op == 6'b100011) begin
          r = blank(4'd5, op);
          r.c.rw = 1'b1;
          r.c.m2r = 1'b1;
          q.push_back(r);
        end
      end
      6'b000000: begin
        r = blank(4'd7, op);
        r.c.asa = 1'b1;
        r.c.aop = 3'b010;
        q.push_back(r);
        r = blank(4'd8, op);
        r.c.rw = 1'b1;
        r.c.rdst = 1'b1;
        q.push_back(r);
      end
      6'b000100, 6'b000101: begin
        r = blank(4'd9, op);
        r.z = z;
        r.c.asa = 1'b1;
        r.c.aop = 3'b001;
        r.c.pcs = 2'b01;
        r.c.pcw = (op == 6'b000100) ? z : !z;
        q.push_back(r);
      end
      6'b000010: begin
        r = blank(4'd10, op);
        r.c.pcs = 2'b10;
        r.c.pcw = 1'b1;
        q.push_back(r);
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        r = blank(4'd11, op);
        r.c.asa = 1'b1;
        r.c.asb = 2'b10;
        r.c.aop = (op == 6'b001100) ? 3'b100 :
                  (op == 6'b001101) ? 3'b011 :
                  (op == 6'b001010) ? 3'b101 : 3'b000;
        q.push_back(r);
        r = blank(4'd12, op);
        r.c.rw = 1'b1;
        q.push_back(r);
      end
      default: pend_illegal = 1'b1;
    endcase
  endtask

  task automatic drive_cycle(input cyc_t r);
    @(negedge clk);
    bus.opcode    = r.op;
    bus.mem_ready = r.rdy;
    bus.zero      = r.z;
    #1;
  endtask

  // Replay the queued trace, comparing state and all controls each cycle
  task automatic run_trace(input string name, output int rw_cnt, output int irw_cnt,
                           output int ill_cnt, output int mw_cnt, output int pcw_cnt);
    ctl_t o;
    rw_cnt = 0; irw_cnt = 0; ill_cnt = 0; mw_cnt = 0; pcw_cnt = 0;
    foreach (q[i]) begin
      drive_cycle(q[i]);
      o = obs_ctl();
      checks++;
      if (bus.state_dbg !== q[i].st) begin
        errors++;
        $display("[TB] FAIL %s state cyc%0d: got %0d want %0d", name, i, bus.state_dbg, q[i].st);
      end
      checks++;
      if (o !== q[i].c) begin
        errors++;
        $display("[TB] FAIL %s ctl cyc%0d st%0d: got %05h want %05h", name, i, q[i].st, o, q[i].c);
      end
      checks++;
      if ((o.mr && o.mw) || (o.rw && o.mw)) begin
        errors++;
        $display("[TB] FAIL %s exclusive cyc%0d: got mr=%0b mw=%0b rw=%0b want no overlap", name, i, o.mr, o.mw, o.rw);
      end
      rw_cnt  += int'(o.rw);
      irw_cnt += int'(o.irw);
      ill_cnt += int'(o.ill);
      mw_cnt  += int'(o.mw);
      pcw_cnt += int'(o.pcw);
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    pend_illegal = 1'b0;
    checks++;
    if (bus.state_dbg !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_release state: got %0d want 0", bus.state_dbg);
    end
  endtask

  task automatic test_reset();
    int rw, irw, ill, mw, pcw, idx;
    do_reset();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state_dbg !== 4'd1) begin
      errors++;
      $display("[TB] FAIL reset_fetch state: got %0d want 1", bus.state_dbg);
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.state_dbg !== 4'd0 || obs_ctl() !== '0) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d: got st=%0d ctl=%05h want st=0 ctl=0", i, bus.state_dbg, obs_ctl());
      end
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.state_dbg !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL reset_seq cyc%0d: got %0d want %0d", i, bus.state_dbg, i);
      end
      @(negedge clk);
      #1;
    end
    // Reset in the middle of a store must drop MemWrite at once
    do_reset();
    model_instr(6'b101011, 1'b0, 0, 2);
    idx = 0;
    foreach (q[i]) if (q[i].st == 4'd6 && idx == 0) idx = i;
    while (q.size() > idx + 1) void'(q.pop_back());
    run_trace("rst_sw", rw, irw, ill, mw, pcw);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.state_dbg !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got MemWrite=%0b st=%0d want 0 0", bus.MemWrite, bus.state_dbg);
    end
  endtask

  task automatic test_rtype();
    int rw, irw, ill, mw, pcw;
    do_reset();
    model_instr(6'b000000, 1'b0, 0, 0);
    model_instr(6'b000000, 1'b1, 1, 0);
    run_trace("rtype", rw, irw, ill, mw, pcw);
    checks++;
    if (rw !== 2) begin
      errors++;
      $display("[TB] FAIL rtype regwrite count: got %0d want 2", rw);
    end
  endtask

  task automatic test_itype();
    int rw, irw, ill, mw, pcw;
    do_reset();
    model_instr(6'b001100, 1'b0, 0, 0);
    model_instr(6'b001101, 1'b0, 0, 0);
    model_instr(6'b001000, 1'b0, 0, 0);
    model_instr(6'b001010, 1'b0, 0, 0);
    run_trace("itype", rw, irw, ill, mw, pcw);
    checks++;
    if (rw !== 4) begin
      errors++;
      $display("[TB] FAIL itype regwrite count: got %0d want 4", rw);
    end
  endtask

  task automatic test_lw();
    int rw, irw, ill, mw, pcw;
    do_reset();
    model_instr(6'b100011, 1'b0, 2, 2);
    run_trace("lw_wait", rw, irw, ill, mw, pcw);
    checks++;
    if (irw !== 1 || rw !== 1) begin
      errors++;
      $display("[TB] FAIL lw counts: got irw=%0d rw=%0d want 1 1", irw, rw);
    end
  endtask

  task automatic test_branch_jump();
    int rw, irw, ill, mw, pcw;
    do_reset();
    model_instr(6'b000100, 1'b1, 0, 0);
    model_instr(6'b000101, 1'b1, 0, 0);
    model_instr(6'b000100, 1'b0, 0, 0);
    model_instr(6'b000101, 1'b0, 0, 0);
    model_instr(6'b000010, 1'b0, 0, 0);
    model_instr(6'b101011, 1'b0, 0, 1);
    run_trace("branch_jump", rw, irw, ill, mw, pcw);
    checks++;
    if (pcw !== 9 || mw !== 2) begin
      errors++;
      $display("[TB] FAIL branch_jump counts: got pcw=%0d mw=%0d want 9 2", pcw, mw);
    end
  endtask

  task automatic test_illegal();
    int rw, irw, ill, mw, pcw;
    do_reset();
    model_instr(6'b111111, 1'b0, 0, 0);
    model_instr(6'b000000, 1'b0, 1, 0);
    run_trace("illegal", rw, irw, ill, mw, pcw);
    checks++;
    if (ill !== 1 || rw !== 1 || mw !== 0) begin
      errors++;
      $display("[TB] FAIL illegal counts: got ill=%0d rw=%0d mw=%0d want 1 1 0", ill, rw, mw);
    end
  endtask

  task automatic test_random();
    int rw, irw, ill, mw, pcw;
    logic [5:0] ops [10];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      model_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    model_instr(6'b000010, 1'b0, 0, 0);
    run_trace("random", rw, irw, ill, mw, pcw);
    checks++;
    if (irw !== 41) begin
      errors++;
      $display("[TB] FAIL random fetch count: got %0d want 41", irw);
    end
  endtask

  // Scenario sequence and summary
  initial begin
    errors        = 0;
    checks        = 0;
    pend_illegal  = 1'b0;
    rst_n         = 1'b0;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_lw();
    test_branch_jump();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
Main control FSM for the multi-cycle MIPS datapath. It decodes the 6-bit opcode latched in the instruction register and sequences fetch, decode, execute, memory and writeback. It drives the 3-bit ALUOp consumed by alu_control_unit, plus all datapath mux selects and write enables. Memory accesses use a req/ready wait-state handshake.

Parameters:
OPW, 6, opcode width
AOPW, 3, ALUOp width (matches alu_control_unit)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  PC load enable (unconditional or resolved branch)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR
RegDst  out  1  dest reg: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
ALUOp  out  3  to alu_control_unit
illegal_op  out  1  one-cycle pulse on unknown opcode
state_dbg  out  4  current state encoding

Behaviour:
- ALUOp encoding: 000 add, 001 sub, 010 R-type (use func), 011 or, 100 and, 101 slt.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
- States (4-bit): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12.
- Outputs are Moore decodes of state, except PCWrite/IRWrite in FETCH and PCWrite in BRANCH, which are Mealy. Any output not listed for a state is 0.
- Reset (rst_n low, asynchronous): state=IDLE, all outputs 0, illegal_op=0. IDLE always moves to FETCH on the next edge. Reset mid-instruction abandons it immediately, with no partial writes after assertion.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite=PCWrite=mem_ready. Stay while !mem_ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R -> R_EXEC
  - beq/bne -> BRANCH
  - j -> JUMP
  - addi/andi/ori/slti -> I_EXEC
  - else -> FETCH with illegal_op=1 for exactly one cycle (registered, asserted in the FETCH cycle that follows)
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEM_WR: MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite = zero for beq, !zero for bne. Next FETCH.
- JUMP: PCSource=10, PCWrite=1. Next FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp: addi 000, andi 100, ori 011, slti 101. Next I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- Opcode is sampled only while the state is DECODE or later. Changes to opcode during FETCH are ignored.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
- Unreachable encodings 13-15 go to IDLE.
- Latencies with mem_ready tied high: R/I-type 4 cycles, lw 5, sw 4, branch 3, jump 3.

Decomposition:
- Shared package/header mips_ctrl_defs: opcode constants, ALUOp constants, state encodings, ALUSrcB and PCSource select codes. The same header is included by alu_control_unit.
- One sub-module: ctrl_next_state (combinational next-state logic from state/opcode/mem_ready). Output decode and the state register stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-FETCH -> all outputs 0, state_dbg=0; release -> state_dbg 0,1,2 on successive edges.
- R-type add (opcode 000000), mem_ready=1 -> states 1,2,7,8,1; ALUOp=010 in R_EXEC; RegWrite=1 with RegDst=1 only in R_WB.
- andi (001100) -> ALUOp=100 in I_EXEC, RegWrite=1 with RegDst=0 in I_WB; ori gives ALUOp=011.
- lw with mem_ready low for 2 cycles in FETCH and in MEM_RD -> FETCH held 3 cycles, IRWrite=1 only on the ready cycle; MEM_RD held 3 cycles; MemtoReg=1 in MEM_WB.
- beq zero=1 -> PCWrite=1, PCSource=01 in BRANCH; bne zero=1 -> PCWrite=0.
- Opcode 111111 -> DECODE returns to FETCH, illegal_op=1 for exactly one cycle, no RegWrite or MemWrite asserted.
